msu_data_fifo: RTL
==================

MSU_DATA_FIFO -- requirements
Module: msu_data_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; SHALL be a power of two and at least 4.
REQ-002 Port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port seek, input, 1 bit: single-cycle pulse from the MSU register block meaning a new data address was written.
REQ-005 Port seek_addr, input, 32 bits: byte address sampled when seek=1.
REQ-006 Port advance, input, 1 bit: single-cycle pulse meaning the CPU consumed the byte on data_out.
REQ-007 Port data_out, output, 8 bits: byte at the FIFO head, feeding msu_data_in.
REQ-008 Port busy, output, 1 bit: feeds msu_status_data_busy.
REQ-009 Port underrun, output, 1 bit: sticky flag meaning advance arrived while the FIFO was empty.
REQ-010 Port mem_req, output, 1 bit: memory fetch request.
REQ-011 Port mem_addr, output, 32 bits: even byte address of the 16-bit word requested.
REQ-012 Port mem_ack, input, 1 bit: single-cycle completion pulse; mem_din is valid in the same cycle.
REQ-013 Port mem_din, input, 16 bits: [7:0] holds the byte at mem_addr, [15:8] the byte at mem_addr+1.

Function
REQ-014 The FIFO SHALL be byte-wide with DEPTH entries, head/tail pointers that wrap modulo DEPTH, and a count of width log2(DEPTH)+1.
REQ-015 data_out SHALL be combinational from the head entry; when the FIFO is empty it SHALL hold the last popped byte (0 after reset).
REQ-016 The FSM SHALL have exactly three states:
 - IDLE: no request outstanding.
 - REQ: request outstanding.
 - DROP: stale request outstanding.
REQ-017 IDLE to REQ SHALL occur when count <= DEPTH-2 and seek=0; mem_req is asserted from the next cycle, with mem_addr = {fetch_addr[31:1],1'b0}.
REQ-018 While in REQ or DROP, mem_req SHALL stay 1 and mem_addr SHALL stay stable until mem_ack.
REQ-019 On mem_ack in REQ, the module SHALL:
 - push mem_din[7:0] then mem_din[15:8], except that the low byte is dropped when skip_low=1;
 - clear skip_low;
 - advance fetch_addr to the next even address;
 - drop mem_req and return to IDLE.
REQ-020 Re-request: the earliest new mem_req SHALL be 1 cycle after the ack cycle.
REQ-021 On seek, the module SHALL in the same edge:
 - empty the FIFO (pointers and count to 0);
 - set fetch_addr=seek_addr and skip_low=seek_addr[0];
 - set busy=1 and clear underrun.
REQ-022 Seek in IDLE SHALL leave the FSM in IDLE; the request for the new address SHALL follow per REQ-017.
REQ-023 Seek in REQ SHALL move the FSM to DROP; seek in DROP SHALL stay in DROP, and the latest seek_addr wins.
REQ-024 mem_ack in DROP SHALL discard mem_din without pushing, leave fetch_addr unchanged, and move the FSM to IDLE.
REQ-025 seek and mem_ack in the same cycle in REQ SHALL be handled as follows:
 - data discarded, seek applied, FSM to IDLE;
 - mem_ack in IDLE SHALL be ignored.
REQ-026 advance with count>0 SHALL pop one byte; advance with count=0 SHALL change nothing except setting underrun=1.
REQ-027 Push and pop in the same cycle SHALL change count by (bytes pushed - 1).
REQ-028 Overflow SHALL be impossible by construction (REQ-017 guarantees room for 2 bytes); advance coinciding with seek SHALL be ignored.
REQ-029 busy SHALL clear on the first edge after a seek at which count becomes nonzero; a further seek SHALL re-arm busy.
REQ-030 fetch_addr SHALL wrap from 0xFFFFFFFE to 0x00000000.

Reset
REQ-031 While RST_N=0, all of the following SHALL hold immediately, without waiting for a clock edge:
 - FSM in IDLE; mem_req=0; mem_addr=0;
 - fetch_addr=0; skip_low=0;
 - FIFO empty; data_out=0; busy=0; underrun=0.
REQ-032 After reset release, fetching SHALL start from address 0 per REQ-017.
REQ-033 A reset asserted while a request is outstanding SHALL abandon that request; a later mem_ack arriving in IDLE SHALL be ignored.

Verification
REQ-034 Even seek: seek_addr=0x100, then ack with mem_din=0xBBAA -> mem_addr=0x100, busy falls, data_out=0xAA; advance -> 0xBB; next mem_addr=0x102.
REQ-035 Odd seek: seek_addr=0x201, then ack with mem_din=0x2211 -> only 0x22 pushed, count=1; next mem_addr=0x202.
REQ-036 Fill: memory always acks after 3 cycles, no advance -> count settles at DEPTH or DEPTH-1 and never exceeds DEPTH; mem_req stays 0 while count > DEPTH-2.
REQ-037 Seek while request outstanding: seek_addr=0x40 while REQ is pending on 0x10 -> the 0x10 data is discarded, the next request is 0x40, and data_out shows the 0x40 byte.
REQ-038 Underrun: advance on an empty FIFO -> underrun=1, count=0, data_out unchanged; the next seek clears underrun.
REQ-039 Mid-operation reset: RST_N low during REQ -> mem_req=0 at once; after release, mem_addr=0.

Source files
------------

// File: rtl/msu_data_fifo.sv
// Byte prefetch FIFO for the MSU data port: fetches 16-bit words from memory,
// queues them as bytes, and restarts cleanly on every seek.
module msu_data_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        seek,
  input  logic [31:0] seek_addr,
  input  logic        advance,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        underrun,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_din
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FILL_LIMIT = (AW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_reg;
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [AW:0]   count_reg;
  logic [31:1]   fetch_addr_reg;
  logic          skip_low_reg;
  logic [7:0]    last_reg;
  logic          busy_reg;
  logic          underrun_reg;
  logic          mem_req_reg;
  logic [31:0]   mem_addr_reg;

  logic          ack_push;
  logic          push_lo;
  logic [1:0]    push_n;
  logic          do_pop;
  logic [AW:0]   count_next;
  logic [AW-1:0] tail_plus1;

  // Only an ack for the current (non-stale) request delivers data; a coincident seek wins.
  assign ack_push   = (state_reg == REQ) && mem_ack && !seek;
  assign push_lo    = ack_push && !skip_low_reg;
  assign push_n     = ack_push ? (skip_low_reg ? 2'd1 : 2'd2) : 2'd0;
  assign do_pop     = advance && !seek && (count_reg != '0);
  assign count_next = count_reg + (AW+1)'(push_n) - (AW+1)'(do_pop);
  assign tail_plus1 = tail_reg + AW'(1);

  assign data_out = (count_reg != '0) ? fifo_mem[head_reg] : last_reg;
  assign busy     = busy_reg;
  assign underrun = underrun_reg;
  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;

  always_ff @(posedge CLK) begin
    if (push_lo) begin
      fifo_mem[tail_reg]   <= mem_din[7:0];
      fifo_mem[tail_plus1] <= mem_din[15:8];
    end else if (ack_push) begin
      fifo_mem[tail_reg]   <= mem_din[15:8];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= IDLE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      fetch_addr_reg <= '0;
      skip_low_reg   <= 1'b0;
      last_reg       <= 8'h00;
      busy_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= 32'h0;
    end else begin
      if (seek) begin
        head_reg       <= '0;
        tail_reg       <= '0;
        count_reg      <= '0;
        fetch_addr_reg <= seek_addr[31:1];
        skip_low_reg   <= seek_addr[0];
        busy_reg       <= 1'b1;
        underrun_reg   <= 1'b0;
      end else begin
        if (do_pop) begin
          head_reg <= head_reg + AW'(1);
          last_reg <= fifo_mem[head_reg];
        end
        if (ack_push) begin
          tail_reg       <= tail_reg + AW'(push_n);
          fetch_addr_reg <= fetch_addr_reg + 31'd1;
          skip_low_reg   <= 1'b0;
        end
        count_reg <= count_next;
        if (busy_reg && (count_next != '0)) begin
          busy_reg <= 1'b0;
        end
        if (advance && (count_reg == '0)) begin
          underrun_reg <= 1'b1;
        end
      end

      // Requests are only issued with room for a full word, so the FIFO cannot overflow.
      case (state_reg)
        IDLE: begin
          if (!seek && (count_reg <= FILL_LIMIT)) begin
            state_reg    <= REQ;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= {fetch_addr_reg, 1'b0};
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
          end else if (seek) begin
            state_reg <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
